// File: rtl/tracker_pkg.sv
// tracker_pkg: steering encodings and FSM state type shared by the tracker and motor blocks
package tracker_pkg;
    typedef enum logic [1:0] {
        ST_STOP     = 2'b00,
        ST_LEFT     = 2'b01,
        ST_RIGHT    = 2'b10,
        ST_STRAIGHT = 2'b11
    } steer_t;

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_SEARCH, S_HALT} fsm_t;

    function automatic logic is_turn(steer_t s);
        return s == ST_LEFT || s == ST_RIGHT;
    endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: accepts a raw sensor bit only after it has differed from the accepted value for DEBOUNCE_CYCLES cycles
//   clk, reset : clock, synchronous active-high reset
//   raw        : raw sensor bit (0 = line)
//   accepted   : debounced bit, resets to 1 (no line)
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic accepted
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // The edge that would bring cnt to DEBOUNCE_CYCLES is the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted <= 1'b1;
            cnt      <= '0;
        end else if (raw == accepted) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            accepted <= raw;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/line_tracker_ctrl.sv
// line_tracker_ctrl: N-sensor debounced line-tracking steering controller with bounded lost-line search
//   clk, reset : clock, synchronous active-high reset
//   en         : run enable, 0 forces stop
//   track      : raw sensors, MSB leftmost, 0 = line detected
//   state      : registered steering command (00 stop, 01 left, 10 right, 11 straight)
//   lost       : registered, high while searching or halted
module line_tracker_ctrl
    import tracker_pkg::*;
#(
    parameter int N_SENSORS       = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOST_TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N_SENSORS-1:0] track,
    output logic [1:0]           state,
    output logic                 lost
);
    localparam int C  = (N_SENSORS - 1) / 2;
    localparam int WW = $clog2(N_SENSORS);
    localparam int TW = LOST_TIMEOUT > 1 ? $clog2(LOST_TIMEOUT) : 1;

    logic [N_SENSORS-1:0] accepted;
    logic [N_SENSORS-1:0] line;
    logic [WW-1:0]        wl;
    logic [WW-1:0]        wr;
    logic                 present;
    steer_t               steer;
    steer_t               last_dir;
    fsm_t                 fsm;
    logic [TW-1:0]        cnt;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_db
        sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .reset    (reset),
            .raw      (track[i]),
            .accepted (accepted[i])
        );
    end

    assign line    = ~accepted;
    assign present = |line;

    // Centre sensor contributes to neither side; equal weights (centre-only, crossing) steer straight.
    always_comb begin
        wl = '0;
        wr = '0;
        for (int k = C + 1; k < N_SENSORS; k++) wl = wl + WW'(line[k]);
        for (int k = 0; k < C; k++) wr = wr + WW'(line[k]);
        steer = !present ? ST_STOP : wl > wr ? ST_LEFT : wr > wl ? ST_RIGHT : ST_STRAIGHT;
    end

    // Outputs are loaded with the value belonging to the state being entered,
    // so they change on the same edge as the FSM. A present line always wins
    // over the search timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= S_IDLE;
            state    <= ST_STOP;
            lost     <= 1'b0;
            cnt      <= '0;
            last_dir <= ST_LEFT;
        end else if (!en) begin
            fsm   <= S_IDLE;
            state <= ST_STOP;
            lost  <= 1'b0;
        end else if (fsm == S_IDLE || present) begin
            fsm   <= S_TRACK;
            state <= steer;
            lost  <= 1'b0;
            if (is_turn(steer)) last_dir <= steer;
        end else begin
            case (fsm)
                S_TRACK: begin
                    fsm   <= S_SEARCH;
                    cnt   <= '0;
                    state <= last_dir;
                    lost  <= 1'b1;
                end
                S_SEARCH: begin
                    if (cnt == TW'(LOST_TIMEOUT - 1)) begin
                        fsm   <= S_HALT;
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_tracker_ctrl.sv
// tb_line_tracker_ctrl: directed self-checking bench for line_tracker_ctrl (N=5, debounce 4, timeout 16)
module tb_line_tracker_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [4:0] track = 5'b11111;
    logic [1:0] state;
    logic       lost;
    int         n_cmp = 0;
    int         n_bad = 0;

    line_tracker_ctrl #(
        .N_SENSORS       (5),
        .DEBOUNCE_CYCLES (4),
        .LOST_TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .track (track),
        .state (state),
        .lost  (lost)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        step(1);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", state); end
        n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL reset_lost got=%b exp=0", lost); end
        reset = 1'b0;
        track = 5'b11011;
        step(4);
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL startup_search_state got=%b exp=01", state); end
        step(1);
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL centre_latency_state got=%b exp=11", state); end
        n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL centre_lost got=%b exp=0", lost); end
    endtask

    task automatic test_steer;
        logic [4:0] vec [3] = '{5'b00111, 5'b11100, 5'b00000};
        logic [1:0] exp [3] = '{2'b01, 2'b10, 2'b11};
        logic [1:0] prev = 2'b11;
        for (int i = 0; i < 3; i++) begin
            track = vec[i];
            step(4);
            n_cmp++; if (state !== prev) begin n_bad++; $display("FAIL steer_hold[%0d] got=%b exp=%b", i, state, prev); end
            step(1);
            n_cmp++; if (state !== exp[i]) begin n_bad++; $display("FAIL steer[%0d] got=%b exp=%b", i, state, exp[i]); end
            n_cmp++; if (lost !== 1'b0) begin n_bad++; $display("FAIL steer_lost[%0d] got=%b exp=0", i, lost); end
            prev = exp[i];
        end
    endtask

    task automatic test_lost_search;
        track = 5'b11100;
        step(5);
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL pre_search_right got=%b exp=10", state); end
        track = 5'b11111;
        step(4);
        n_cmp++; if (state !== 2'b10 || lost !== 1'b0) begin n_bad++; $display("FAIL pre_search_track got=%b/%b exp=10/0", state, lost); end
        for (int i = 0; i < 16; i++) begin
            step(1);
            n_cmp++; if (state !== 2'b10 || lost !== 1'b1) begin n_bad++; $display("FAIL search_cycle[%0d] got=%b/%b exp=10/1", i, state, lost); end
        end
        step(1);
        n_cmp++; if (state !== 2'b00 || lost !== 1'b1) begin n_bad++; $display("FAIL halt_entry got=%b/%b exp=00/1", state, lost); end
        step(3);
        n_cmp++; if (state !== 2'b00 || lost !== 1'b1) begin n_bad++; $display("FAIL halt_hold got=%b/%b exp=00/1", state, lost); end
        track = 5'b11011;
        step(5);
        n_cmp++; if (state !== 2'b11 || lost !== 1'b0) begin n_bad++; $display("FAIL halt_recover got=%b/%b exp=11/0", state, lost); end
    endtask

    task automatic test_glitch;
        track = 5'b11010;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL glitch_pulse[%0d] got=%b exp=11", i, state); end
        end
        track = 5'b11011;
        for (int i = 0; i < 6; i++) begin
            step(1);
            n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL glitch_after[%0d] got=%b exp=11", i, state); end
        end
    endtask

    task automatic test_reset_in_search;
        track = 5'b11111;
        step(5);
        n_cmp++; if (state !== 2'b10 || lost !== 1'b1) begin n_bad++; $display("FAIL rs_search_entry got=%b/%b exp=10/1", state, lost); end
        step(6);
        reset = 1'b1;
        step(1);
        n_cmp++; if (state !== 2'b00 || lost !== 1'b0) begin n_bad++; $display("FAIL rs_reset got=%b/%b exp=00/0", state, lost); end
        reset = 1'b0;
        step(2);
        n_cmp++; if (state !== 2'b01 || lost !== 1'b1) begin n_bad++; $display("FAIL rs_last_dir got=%b/%b exp=01/1", state, lost); end
    endtask

    task automatic test_en_drop;
        track = 5'b00111;
        step(5);
        n_cmp++; if (state !== 2'b01 || lost !== 1'b0) begin n_bad++; $display("FAIL en_track_left got=%b/%b exp=01/0", state, lost); end
        en = 1'b0;
        step(1);
        n_cmp++; if (state !== 2'b00 || lost !== 1'b0) begin n_bad++; $display("FAIL en_drop got=%b/%b exp=00/0", state, lost); end
        step(1);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL en_idle_hold got=%b exp=00", state); end
        en = 1'b1;
        step(1);
        n_cmp++; if (state !== 2'b01 || lost !== 1'b0) begin n_bad++; $display("FAIL en_resume got=%b/%b exp=01/0", state, lost); end
    endtask

    task automatic test_timeout_vs_line;
        track = 5'b11111;
        step(5);
        n_cmp++; if (state !== 2'b01 || lost !== 1'b1) begin n_bad++; $display("FAIL tl_search_entry got=%b/%b exp=01/1", state, lost); end
        step(11);
        track = 5'b11011;
        step(4);
        n_cmp++; if (state !== 2'b01 || lost !== 1'b1) begin n_bad++; $display("FAIL tl_last_search got=%b/%b exp=01/1", state, lost); end
        step(1);
        n_cmp++; if (state !== 2'b11 || lost !== 1'b0) begin n_bad++; $display("FAIL tl_line_wins got=%b/%b exp=11/0", state, lost); end
    endtask

    initial begin
        test_reset();
        test_steer();
        test_lost_search();
        test_glitch();
        test_reset_in_search();
        test_en_drop();
        test_timeout_vs_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_tracker_ctrl.md
# line_tracker_ctrl

Parametrised N-sensor line-tracking steering controller. It is the successor to the 3-sensor tracker policy and sits between the IR tracker sensor inputs and the motor driver. It debounces each sensor and steers from a left/right weight comparison. A lost-line recovery state machine keeps turning toward the last-seen side for a bounded time, then stops. The `state` output encoding is unchanged, so the motor block needs no modification.

## Interface
- `N_SENSORS`, default 5: number of tracker sensors; odd, ≥3.
- `DEBOUNCE_CYCLES`, default 4: cycles a raw sensor bit must hold before it is accepted; ≥1.
- `LOST_TIMEOUT`, default 1024: maximum cycles spent searching before halting; ≥1.

Ports (name, direction, width, meaning):
- `clk`  input  1  system clock; single clock domain.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  run enable; 0 forces stop.
- `track`  input  `N_SENSORS`  raw sensor bits. Bit `N_SENSORS-1` is leftmost, bit 0 is rightmost. A bit value of 0 means line detected.
- `state`  output  2  steering command: 00 stop, 01 turn left, 10 turn right, 11 straight.
- `lost`  output  1  high while in SEARCH or HALT.

## Operation
- **Debounce**, per bit:
  - A counter increments while the raw bit differs from the accepted bit and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the accepted bit takes the raw value and the counter clears.
  - Accepted bits reset to all 1 (no line).
- **Line vector:** `line = ~accepted`. Center index `C = (N_SENSORS-1)/2`.
- **Weights:**
  - `wl` = popcount of `line[N-1:C+1]`.
  - `wr` = popcount of `line[C-1:0]`.
  - Both are unsigned, width `$clog2(N_SENSORS)`.
- **Steering decision** when the line is present (`line != 0`):
  - `wl > wr` → 01 (turn left).
  - `wr > wl` → 10 (turn right).
  - Otherwise → 11 (straight). This covers the centre-only case and the all-on crossing.
- **`last_dir` register:** records 01 or 10 whenever a turn is issued in TRACK; resets to 01.
- **FSM states:** IDLE, TRACK, SEARCH, HALT.
  - IDLE: `state` = 00. Moves to TRACK when `en` = 1.
  - TRACK: `state` = steering decision. If `line == 0`, moves to SEARCH and loads the timeout counter with 0.
  - SEARCH: `state` = `last_dir`; the counter increments each cycle.
    - `line != 0` → TRACK.
    - Otherwise, if the counter reaches `LOST_TIMEOUT-1` → HALT.
  - HALT: `state` = 00. `line != 0` → TRACK.
  - From any state, `en` = 0 → IDLE on the next edge. This overrides all other transitions.
- **Simultaneous events:**
  - Line reappearing in the same cycle that the timeout expires → TRACK takes priority.
  - `reset` overrides `en` and all other inputs.

## Timing
- **Reset values** (following a clock edge with `reset` = 1):
  - `state` = 00, `lost` = 0, FSM = IDLE.
  - Accepted bits all 1, all counters 0, `last_dir` = 01.
- Reset mid-operation (including during SEARCH) returns everything to these values; no partial state is retained.
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Latency:** a raw change held stable appears on the accepted bit after `DEBOUNCE_CYCLES` edges. `state`/`lost` reflect it one edge later, so total latency is `DEBOUNCE_CYCLES+1`.
- **Glitches:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **SEARCH duration:** exactly `LOST_TIMEOUT` cycles of turning before `state` = 00. The timeout counter saturates and never wraps.
- **`en`:** deasserting `en` sets `state` = 00 on the next edge. Re-asserting `en` enters TRACK one edge later.

## Structure
- **Package `tracker_pkg`:**
  - Steering encodings `ST_STOP`, `ST_LEFT`, `ST_RIGHT`, `ST_STRAIGHT`.
  - FSM state type (IDLE/TRACK/SEARCH/HALT).
  - Shared with the motor block.
- **Sub-module `sensor_debounce`** (one bit, parameter `DEBOUNCE_CYCLES`): instantiated `N_SENSORS` times via generate.
- Weight popcounts, steering decision and FSM live in the top module.

## Test plan
All scenarios use `N_SENSORS`=5, `DEBOUNCE_CYCLES`=4, `LOST_TIMEOUT`=16.
1. Reset, `en`=1, `track`=5'b11011 (centre line) held → `state`=11 five edges after the change; `lost`=0.
2. `track`=5'b00111 → `state`=01. Then `track`=5'b11100 → `state`=10. Then `track`=5'b00000 (crossing) → `state`=11.
3. After a right turn, `track`=5'b11111 → `lost`=1 and `state`=10 for exactly 16 cycles, then `state`=00 with `lost`=1. Then `track`=5'b11011 → `state`=11 and `lost`=0.
4. A 3-cycle pulse on `track[0]`=0 while centred → `state` stays 11 throughout.
5. `reset` asserted during SEARCH cycle 7 → next edge `state`=00, `lost`=0. After release, the line is absent and `en`=1, so SEARCH is entered with `last_dir`=01.
6. `en` dropped while in TRACK turning left → `state`=00 next edge. Timeout expiry coinciding with line return → TRACK, `lost`=0.
